z80_bus_target: RTL and testbench

- Target (responder) side of the Z80 external bus: decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n driven by the CPU core wrapper.
- Converts each memory or I/O access into a single req/ack transaction on a synchronous backend port, and stretches the CPU cycle with wait_n until the backend answers.
- Answers interrupt-acknowledge cycles with a programmable vector; ignores refresh cycles.
- Sits between the CPU wrapper and the memory/peripheral fabric, on the same clk.

---
 rtl/z80_bus_target.sv | 159 +++++++++++++++
 tb/tb_z80_bus_target.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_target.sv
// z80_bus_target: responder side of the Z80 external bus.
// Turns each CPU memory / I/O cycle into exactly one req/ack transaction on a
// synchronous backend port and holds wait_n low until the backend answers.
// Interrupt-acknowledge cycles are answered locally with int_vector.
// Refresh cycles are ignored.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   A, cpu_dout         CPU address and write data
//   cpu_di              registered read data / interrupt vector to the CPU
//   m1_n .. rfsh_n      registered, active-low CPU strobes
//   wait_n              combinational wait request to the CPU (active low)
//   int_vector, int_ack vector for INTA, one-cycle pulse when INTA is serviced
//   be_req .. be_wdata  backend request (level), direction, space, addr, data
//   be_rdata, be_ack    backend read data and completion
//   timeout             one-cycle pulse when an access is abandoned
module z80_bus_target #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  FLOAT_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  input  logic [7:0]  int_vector,
  output logic        int_ack,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack,
  output logic        timeout
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DATA_W-1:0]  cpu_di_d;
  logic               be_req_d, be_we_d, be_io_d;
  logic [ADDR_W-1:0]  be_addr_d;
  logic [DATA_W-1:0]  be_wdata_d;
  logic               int_ack_d, timeout_d;

  logic mem_start, io_start, inta, expired;

  // Strobe decode on the current (already registered) CPU strobes.
  assign mem_start = !mreq_n && rfsh_n && (!rd_n || !wr_n);
  assign io_start  = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign inta      = !iorq_n && !m1_n;
  assign expired   = (cnt == CNT_W'(TIMEOUT - 1));

  // Wait is pulled low in the strobe cycle itself so the CPU sees it in T2;
  // gated by reset_n so it releases immediately on a mid-cycle reset.
  assign wait_n = !reset_n ||
                  !(((state == IDLE) && (mem_start || io_start) && !inta) ||
                    (state == REQ));

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cpu_di   <= '0;
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_addr  <= '0;
      be_wdata <= '0;
      int_ack  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cpu_di   <= cpu_di_d;
      be_req   <= be_req_d;
      be_we    <= be_we_d;
      be_io    <= be_io_d;
      be_addr  <= be_addr_d;
      be_wdata <= be_wdata_d;
      int_ack  <= int_ack_d;
      timeout  <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cpu_di_d   = cpu_di;
    be_req_d   = be_req;
    be_we_d    = be_we;
    be_io_d    = be_io;
    be_addr_d  = be_addr;
    be_wdata_d = be_wdata;
    int_ack_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state)
      IDLE: begin
        // INTA takes priority over an I/O start seen in the same cycle.
        if (inta) begin
          cpu_di_d  = int_vector;
          int_ack_d = 1'b1;
          state_d   = HOLD;
        end else if (mem_start || io_start) begin
          be_addr_d  = A;
          be_we_d    = !wr_n;
          be_io_d    = !iorq_n;
          be_wdata_d = cpu_dout;
          be_req_d   = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
        end
      end

      REQ: begin
        cnt_d = cnt + CNT_W'(1);
        // Ack wins over expiry in the same cycle.
        if (be_ack) begin
          be_req_d = 1'b0;
          if (!be_we) cpu_di_d = be_rdata;
          state_d = HOLD;
        end else if (expired) begin
          be_req_d  = 1'b0;
          if (!be_we) cpu_di_d = FLOAT_DATA;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        // Wait for the CPU to end the cycle so one cycle = one transaction.
        if (mreq_n && iorq_n) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed self-checking bench for z80_bus_target (TIMEOUT = 8).
module tb_z80_bus_target;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic        wait_n;
  logic [7:0]  int_vector;
  logic        int_ack;
  logic        be_req, be_we, be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [7:0]  be_rdata;
  logic        be_ack;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;

  // Activity counters sampled mid-cycle.
  int req_cnt = 0, wait_cnt = 0, to_cnt = 0, iack_cnt = 0, rise_cnt = 0;
  logic prev_req = 1'b0;

  logic [7:0] exp_di;

  z80_bus_target #(.TIMEOUT(8), .FLOAT_DATA(8'hFF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A          (A),
    .cpu_dout   (cpu_dout),
    .cpu_di     (cpu_di),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rfsh_n     (rfsh_n),
    .wait_n     (wait_n),
    .int_vector (int_vector),
    .int_ack    (int_ack),
    .be_req     (be_req),
    .be_we      (be_we),
    .be_io      (be_io),
    .be_addr    (be_addr),
    .be_wdata   (be_wdata),
    .be_rdata   (be_rdata),
    .be_ack     (be_ack),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      req_cnt  <= req_cnt + (be_req ? 1 : 0);
      wait_cnt <= wait_cnt + (!wait_n ? 1 : 0);
      to_cnt   <= to_cnt + (timeout ? 1 : 0);
      iack_cnt <= iack_cnt + (int_ack ? 1 : 0);
      rise_cnt <= rise_cnt + ((be_req && !prev_req) ? 1 : 0);
    end
    prev_req <= be_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic release_strobes;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One CPU access; ack_cycle = REQ cycle carrying the ack (0 = never ack).
  task automatic run_access(input string tag, input logic io, input logic we,
                            input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] rd, input int ack_cycle, input int hold);
    int r0, q0, w0, t0, n;
    r0 = rise_cnt; q0 = req_cnt; w0 = wait_cnt; t0 = to_cnt;
    n = (ack_cycle == 0) ? 8 : ack_cycle;
    if (!we) exp_di = (ack_cycle == 0) ? 8'hFF : rd;
    A = addr; cpu_dout = wd; be_rdata = rd;
    if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
    if (we) wr_n = 1'b0; else rd_n = 1'b0;
    @(negedge clk);
    check({tag, "_wait_t1"}, 32'(wait_n), 32'(0));
    step;
    check({tag, "_req"},   32'(be_req),   32'(1));
    check({tag, "_addr"},  32'(be_addr),  32'(addr));
    check({tag, "_we"},    32'(be_we),    32'(we));
    check({tag, "_io"},    32'(be_io),    32'(io));
    check({tag, "_wdata"}, 32'(be_wdata), 32'(wd));
    for (int i = 1; i <= n; i++) begin
      if (i == ack_cycle) be_ack = 1'b1;
      step;
      be_ack = 1'b0;
    end
    check({tag, "_req_off"}, 32'(be_req),  32'(0));
    check({tag, "_wait_off"}, 32'(wait_n), 32'(1));
    check({tag, "_to_pulse"}, 32'(timeout), 32'(ack_cycle == 0));
    check({tag, "_di"}, 32'(cpu_di), 32'(exp_di));
    be_rdata = 8'h11;
    repeat (hold) step;
    check({tag, "_di_hold"}, 32'(cpu_di), 32'(exp_di));
    check({tag, "_req_hold"}, 32'(be_req), 32'(0));
    release_strobes;
    step; step;
    check({tag, "_n_trans"}, 32'(rise_cnt - r0), 32'(1));
    check({tag, "_req_cyc"}, 32'(req_cnt - q0),  32'(n));
    check({tag, "_wait_cyc"}, 32'(wait_cnt - w0), 32'(n + 1));
    check({tag, "_to_cnt"}, 32'(to_cnt - t0), 32'(ack_cycle == 0));
  endtask

  initial begin
    int r0, w0, a0;
    reset_n = 1'b0;
    A = '0; cpu_dout = '0; int_vector = '0; be_rdata = '0; be_ack = 1'b0;
    release_strobes;
    exp_di = 8'h00;
    #12;
    check("rst_wait",  32'(wait_n),   32'(1));
    check("rst_di",    32'(cpu_di),   32'(0));
    check("rst_req",   32'(be_req),   32'(0));
    check("rst_addr",  32'(be_addr),  32'(0));
    check("rst_wdata", 32'(be_wdata), 32'(0));
    check("rst_flags", 32'({be_we, be_io, int_ack, timeout}), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    step;

    // Memory read, ack on 3rd REQ cycle.
    run_access("memrd", 1'b0, 1'b0, 16'h4000, 8'h00, 8'h3C, 3, 2);
    // I/O write, ack on 1st REQ cycle; cpu_di must keep previous read.
    run_access("iowr", 1'b1, 1'b1, 16'h7F10, 8'hA5, 8'h00, 1, 1);

    // Interrupt acknowledge (second pass also has rd_n low: INTA must win).
    for (int k = 0; k < 2; k++) begin
      r0 = rise_cnt; w0 = wait_cnt; a0 = iack_cnt;
      int_vector = (k == 0) ? 8'hE8 : 8'hD7;
      m1_n = 1'b0; iorq_n = 1'b0; rd_n = (k == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("inta_wait", 32'(wait_n), 32'(1));
      step;
      check("inta_di",  32'(cpu_di),  32'(int_vector));
      check("inta_ack", 32'(int_ack), 32'(1));
      step;
      check("inta_ack_off", 32'(int_ack), 32'(0));
      release_strobes;
      step; step;
      check("inta_no_req", 32'(rise_cnt - r0), 32'(0));
      check("inta_no_wait", 32'(wait_cnt - w0), 32'(0));
      check("inta_ack_cnt", 32'(iack_cnt - a0), 32'(1));
    end
    exp_di = 8'hD7;

    // Timeout: no ack -> 8 REQ cycles, FLOAT_DATA returned.
    run_access("tmo", 1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 0, 1);
    // Ack on the expiry cycle: ack wins.
    run_access("tmo_ack", 1'b0, 1'b0, 16'h1235, 8'h00, 8'h77, 8, 1);

    // Refresh, with and without rd_n low, never starts anything.
    r0 = rise_cnt; w0 = wait_cnt;
    for (int k = 0; k < 2; k++) begin
      mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = k[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      check("rfsh_wait", 32'(wait_n), 32'(1));
      step; step;
      check("rfsh_req", 32'(be_req), 32'(0));
      release_strobes;
      step;
    end
    check("rfsh_no_trans", 32'(rise_cnt - r0), 32'(0));
    check("rfsh_no_wait", 32'(wait_cnt - w0), 32'(0));

    // Long rd_n after ack: still exactly one transaction.
    run_access("retrig", 1'b0, 1'b0, 16'h0100, 8'h00, 8'h99, 2, 10);

    // Stray ack in IDLE is ignored.
    be_ack = 1'b1; be_rdata = 8'h42;
    step;
    be_ack = 1'b0;
    step;
    check("stray_req", 32'(be_req), 32'(0));
    check("stray_di",  32'(cpu_di), 32'(exp_di));

    // Reset two cycles into REQ.
    A = 16'h2222; mreq_n = 1'b0; rd_n = 1'b0;
    step; step; step;
    check("mid_req", 32'(be_req), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req",  32'(be_req), 32'(0));
    check("mid_rst_wait", 32'(wait_n), 32'(1));
    check("mid_rst_di",   32'(cpu_di), 32'(0));
    release_strobes;
    exp_di = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    step;
    run_access("post_rst", 1'b0, 1'b0, 16'h3003, 8'h00, 8'hC4, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
